// File: rtl/tt_sweep_ctrl_if.sv
// Purpose: bundle of sweep-control signals between a controller user and tt_sweep_ctrl.
// Latency: none, wires only.
// Backpressure: none; start is a level sampled only while the controller is idle.
interface tt_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       f_in;
    logic [2:0] xyz;
    logic       busy;
    logic       done;
    logic [7:0] tt;
    logic       mismatch;
    logic [3:0] err_cnt;

    // Side that requests sweeps and hosts the circuit under test.
    modport master (
        output start, abort, f_in,
        input  xyz, busy, done, tt, mismatch, err_cnt
    );

    // Sweep controller side.
    modport slave (
        input  start, abort, f_in,
        output xyz, busy, done, tt, mismatch, err_cnt
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Purpose: sweeps xyz over 0..7, captures f_in into tt[], optionally counts mismatches against G = X&Y | ~X&Z (macro TT_CHECK_EN).
// Latency: start sampled in cycle 0 -> done pulse in cycle 8*HOLD+1; each combination held HOLD cycles.
// Backpressure: none; start ignored unless idle, abort cancels a sweep on the next edge.
module tt_sweep_ctrl #(
    parameter int unsigned HOLD = 1
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_ctrl_if.slave     sweep_if
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] HOLD_L = 4'(HOLD);

    logic [1:0] state_q, state_d;
    logic [2:0] xyz_q,   xyz_d;
    logic [3:0] hold_q,  hold_d;
    logic [7:0] tt_q,    tt_d;
    logic       sample;
    logic       sweep_clr;

    // Next-state logic: walk the combinations, sample on the last hold cycle.
    always_comb begin
        state_d   = state_q;
        xyz_d     = xyz_q;
        hold_d    = hold_q;
        tt_d      = tt_q;
        sample    = 1'b0;
        sweep_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sweep_if.start) begin
                    state_d   = S_DRIVE;
                    xyz_d     = 3'd0;
                    hold_d    = HOLD_L;
                    tt_d      = 8'h00;
                    sweep_clr = 1'b1;
                end
            end
            S_DRIVE: begin
                if (sweep_if.abort) begin
                    // Partial tt is deliberately kept for inspection.
                    state_d = S_IDLE;
                    xyz_d   = 3'd0;
                    hold_d  = 4'd0;
                end else if (hold_q == 4'd1) begin
                    sample           = 1'b1;
                    tt_d[xyz_q]      = sweep_if.f_in;
                    if (xyz_q == 3'd7) begin
                        state_d = S_DONE;
                        xyz_d   = 3'd0;
                        hold_d  = 4'd0;
                    end else begin
                        xyz_d  = xyz_q + 3'd1;
                        hold_d = HOLD_L;
                    end
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                xyz_d   = 3'd0;
                hold_d  = 4'd0;
            end
        endcase
    end

    // Sweep state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            xyz_q   <= 3'd0;
            hold_q  <= 4'd0;
            tt_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            xyz_q   <= xyz_d;
            hold_q  <= hold_d;
            tt_q    <= tt_d;
        end
    end

`ifdef TT_CHECK_EN
    logic       golden;
    logic [3:0] err_q, err_d;

    // Reference function evaluated on the combination currently driven.
    assign golden = (xyz_q[2] & xyz_q[1]) | (~xyz_q[2] & xyz_q[0]);

    // At most 8 samples per sweep, so the 4-bit count never wraps.
    always_comb begin
        err_d = err_q;
        if (sweep_clr) begin
            err_d = 4'd0;
        end else if (sample && (sweep_if.f_in != golden)) begin
            err_d = err_q + 4'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 4'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sweep_if.err_cnt  = err_q;
    assign sweep_if.mismatch = (err_q != 4'd0);
`else
    logic unused_chk;
    assign unused_chk        = sample ^ sweep_clr;
    assign sweep_if.err_cnt  = 4'd0;
    assign sweep_if.mismatch = 1'b0;
`endif

    assign sweep_if.xyz  = xyz_q;
    assign sweep_if.busy = (state_q == S_DRIVE);
    assign sweep_if.done = (state_q == S_DONE);
    assign sweep_if.tt   = tt_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;

    logic clk;
    logic rst;
    int   mode;
    int   errors;
    int   checks;

`ifdef TT_CHECK_EN
    localparam int E_STUCK = 4;
    localparam int E_AND   = 2;
    localparam int E_PART  = 2;
`else
    localparam int E_STUCK = 0;
    localparam int E_AND   = 0;
    localparam int E_PART  = 0;
`endif

    tt_sweep_ctrl_if if1 ();
    tt_sweep_ctrl_if if3 ();

    tt_sweep_ctrl #(.HOLD(1)) u_h1 (.clk(clk), .rst(rst), .sweep_if(if1));
    tt_sweep_ctrl #(.HOLD(3)) u_h3 (.clk(clk), .rst(rst), .sweep_if(if3));

    // Circuit-under-test model: 0 = correct X&Y|~X&Z, 1 = stuck at 0, 2 = X&Y.
    function automatic logic fmodel(input logic [2:0] v, input int m);
        case (m)
            1:       return 1'b0;
            2:       return v[2] & v[1];
            default: return (v[2] & v[1]) | (~v[2] & v[0]);
        endcase
    endfunction

    assign if1.f_in = fmodel(if1.xyz, mode);
    assign if3.f_in = fmodel(if3.xyz, 0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_busy"}, 32'(if1.busy), 0);
        check({tag, "_done"}, 32'(if1.done), 0);
        check({tag, "_xyz"},  32'(if1.xyz),  0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mode   = 0;
        rst    = 1'b1;
        if1.start = 1'b0; if1.abort = 1'b0;
        if3.start = 1'b0; if3.abort = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;
        check_idle1("rst");
        check("rst_tt",   32'(if1.tt),       0);
        check("rst_err",  32'(if1.err_cnt),  0);
        check("rst_mis",  32'(if1.mismatch), 0);
        check("rst3_busy", 32'(if3.busy),    0);

        // HOLD=1 correct sweep; repeated start in cycle 3 and in done cycle ignored.
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("h1_xyz",  32'(if1.xyz),  32'(c - 1));
            check("h1_busy", 32'(if1.busy), 1);
            check("h1_done", 32'(if1.done), 0);
            if1.start = (c == 3);
            tick;
        end
        check("h1_done9", 32'(if1.done), 1);
        check("h1_busy9", 32'(if1.busy), 0);
        check("h1_tt",    32'(if1.tt),   32'h00CA);
        check("h1_err",   32'(if1.err_cnt),  0);
        check("h1_mis",   32'(if1.mismatch), 0);
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        check_idle1("h1_c10");
        check("h1_tt_hold", 32'(if1.tt), 32'h00CA);
        tick;
        check("h1_c11_busy", 32'(if1.busy), 0);

        // HOLD=3 correct sweep.
        if3.start = 1'b1;
        tick;
        if3.start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            check("h3_xyz",  32'(if3.xyz),  32'((c - 1) / 3));
            check("h3_busy", 32'(if3.busy), 1);
            check("h3_done", 32'(if3.done), 0);
            tick;
        end
        check("h3_done25", 32'(if3.done), 1);
        check("h3_tt",     32'(if3.tt),   32'h00CA);
        tick;
        check("h3_done26", 32'(if3.done), 0);

        // Stuck-at-0 circuit.
        mode = 1;
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        repeat (8) tick;
        check("s0_done", 32'(if1.done),     1);
        check("s0_tt",   32'(if1.tt),       0);
        check("s0_err",  32'(if1.err_cnt),  32'(E_STUCK));
        check("s0_mis",  32'(if1.mismatch), 32'(E_STUCK != 0));
        repeat (3) tick;
        check("s0_err_hold", 32'(if1.err_cnt), 32'(E_STUCK));

        // X&Y circuit.
        mode = 2;
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        repeat (8) tick;
        check("and_done", 32'(if1.done),    1);
        check("and_tt",   32'(if1.tt),      32'h00C0);
        check("and_err",  32'(if1.err_cnt), 32'(E_AND));
        tick;

        // Abort at xyz=3, then restart in cycle 6.
        mode = 0;
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        tick; tick; tick;
        check("ab_xyz4", 32'(if1.xyz), 3);
        if1.abort = 1'b1;
        tick;
        if1.abort = 1'b0;
        check_idle1("ab_c5");
        check("ab_tt",  32'(if1.tt),      32'h0002);
        check("ab_err", 32'(if1.err_cnt), 0);
        tick;
        check("ab_c6_done", 32'(if1.done), 0);
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        check("ab_re_busy", 32'(if1.busy), 1);
        check("ab_re_tt",   32'(if1.tt),   0);
        repeat (8) tick;
        check("ab_re_done", 32'(if1.done), 1);
        check("ab_re_tt2",  32'(if1.tt),   32'h00CA);
        tick;

        // Abort in IDLE has no effect; start and abort together start.
        if1.abort = 1'b1;
        tick;
        if1.abort = 1'b0;
        check("abi_busy", 32'(if1.busy), 0);
        check("abi_tt",   32'(if1.tt),   32'h00CA);
        mode = 2;
        if1.start = 1'b1;
        if1.abort = 1'b1;
        tick;
        if1.start = 1'b0;
        if1.abort = 1'b0;
        check("sa_busy", 32'(if1.busy), 1);

        // Reset mid-sweep (cycle 5) with start held: reset wins.
        tick; tick; tick; tick;
        check("rm_xyz",  32'(if1.xyz),      4);
        check("rm_err",  32'(if1.err_cnt),  32'(E_PART));
        check("rm_mis",  32'(if1.mismatch), 32'(E_PART != 0));
        rst = 1'b1;
        if1.start = 1'b1;
        tick;
        rst = 1'b0;
        if1.start = 1'b0;
        check_idle1("rm_c6");
        check("rm_tt",   32'(if1.tt),       0);
        check("rm_err0", 32'(if1.err_cnt),  0);
        check("rm_mis0", 32'(if1.mismatch), 0);
        tick;
        check("rm_c7_busy", 32'(if1.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
